// File: rtl/dmem_responder_if.sv
// Load/store channel between the core's memory-access stage and the data memory:
// valid/ready request, one-cycle response pulse, and a busy flag that stalls the pipeline.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with a fixed number of wait states; flags misaligned or
// out-of-range accesses instead of touching memory.
//
// state | meaning
// IDLE  | ready for a request; handshake when req_valid is high at the edge
// WAIT  | access in flight, wait-state down-counter running to zero
// RESP  | one-cycle response pulse; access was performed on the edge entering here
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  dmem_responder_if.slave  bus
);
  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [3:0]  cnt;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  logic             handshake;
  logic             enter_resp;
  logic             acc_write;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [29:0]      acc_word;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_err;

  assign handshake = (state == IDLE) && bus.req_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.req_valid) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == RESP) && (state != RESP);

  // With no wait states the access happens on the handshake edge itself,
  // before the capture registers are loaded, so take the live request then.
  assign acc_write = (state == IDLE) ? bus.req_write : write_q;
  assign acc_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
  assign acc_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
  assign acc_word  = acc_addr[31:2];
  assign acc_idx   = acc_word[IDX_W-1:0];
  assign acc_err   = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_word} >= 32'(DEPTH));

  // Memory shares the reset domain but is never cleared; an edge with rst_n low
  // therefore can never commit a store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (handshake) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        err_q   <= acc_err;
        rdata_q <= (acc_write || acc_err) ? 32'd0 : mem[acc_idx];
        if (acc_write && !acc_err) mem[acc_idx] <= acc_wdata;
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule
